// File: rtl/ccm_row_dispatcher.sv
// CCM-side consumer of the IDP address tracker: shadows tracker occupancy,
// dispatches the head row pair to the decoder array and pops it when both rows complete.
module ccm_row_dispatcher #(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned DONE_TIMEOUT = 1023,
  localparam int unsigned OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_seen,
  input  logic [ADDR_W-1:0] row0_addr,
  input  logic [ADDR_W-1:0] row1_addr,
  output logic              pop,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              done,
  output logic [OCC_W-1:0]  occupancy,
  output logic              busy,
  output logic              err_overflow,
  output logic              err_timeout
);

  localparam int unsigned TMO_W = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    POP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] r0_q, r0_d;
  logic [ADDR_W-1:0] r1_q, r1_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              busy_q, busy_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_tmo_q, err_tmo_d;
  logic              pop_c;
  logic [TMO_W-1:0]  tmo_inc;
  logic              tmo_hit;

  // The tracker ignores a read colliding with a write, so the pop waits for a push-free cycle.
  assign pop_c   = (state_q == POP) && !push_seen;
  assign tmo_inc = tmo_q + TMO_W'(1);
  assign tmo_hit = (tmo_inc == TMO_W'(DONE_TIMEOUT));

  always_comb begin
    state_d     = state_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    tmo_d       = tmo_q;
    err_tmo_d   = err_tmo_q;
    err_ovf_d   = err_ovf_q;
    occ_d       = occ_q;

    case (state_q)
      IDLE: begin
        if (occ_q >= OCC_W'(2)) state_d = LATCH;
      end
      LATCH: begin
        r0_d        = row0_addr;
        r1_d        = row1_addr;
        req_valid_d = 1'b1;
        req_addr_d  = row0_addr;
        state_d     = ISSUE0;
      end
      ISSUE0: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          tmo_d       = '0;
          state_d     = WAIT0;
        end
      end
      WAIT0: begin
        if (done || tmo_hit) begin
          err_tmo_d   = err_tmo_q | !done;
          req_valid_d = 1'b1;
          req_addr_d  = r1_q;
          state_d     = ISSUE1;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      ISSUE1: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          tmo_d       = '0;
          state_d     = WAIT1;
        end
      end
      WAIT1: begin
        if (done || tmo_hit) begin
          err_tmo_d = err_tmo_q | !done;
          state_d   = POP;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      POP: begin
        if (!push_seen) state_d = IDLE;
      end
      default: begin
        req_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    // Shadow occupancy: push saturates at DEPTH, pop retires a pair.
    if (push_seen) begin
      if (occ_q == OCC_W'(DEPTH)) err_ovf_d = 1'b1;
      else                        occ_d     = occ_q + OCC_W'(1);
    end else if (pop_c) begin
      occ_d = occ_q - OCC_W'(2);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r0_q        <= '0;
      r1_q        <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      occ_q       <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      occ_q       <= occ_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      err_ovf_q   <= err_ovf_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  assign pop          = pop_c;
  assign req_valid    = req_valid_q;
  assign req_addr     = req_addr_q;
  assign occupancy    = occ_q;
  assign busy         = busy_q;
  assign err_overflow = err_ovf_q;
  assign err_timeout  = err_tmo_q;

endmodule
